fpu_share_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one `fpu_double` instance among `N_REQ` requesters, such as the x/y/z update engines of the attractor integrator. It accepts one operation at a time from the winning requester and drives the FPU enable/reset handshake. It captures the result and flags, returns them with a one-cycle `done` pulse, and then pulses the FPU reset before the next grant. A watchdog terminates any operation whose `ready` never arrives.

---
 rtl/fpu_pkg.sv | 37 +++
 rtl/rr_pick.sv | 34 +++
 rtl/fpu_share_arb.sv | 179 +++++++++++++++++
 tb/tb_fpu_share_arb.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU op/rounding codes, flag indices, arbiter states, double constants
package fpu_pkg;

    typedef enum logic [2:0] {
        FPU_ADD = 3'd0,
        FPU_SUB = 3'd1,
        FPU_MUL = 3'd2,
        FPU_DIV = 3'd3
    } fpu_op_e;

    typedef enum logic [1:0] {
        RM_NEAREST = 2'd0,
        RM_ZERO    = 2'd1,
        RM_POS_INF = 2'd2,
        RM_NEG_INF = 2'd3
    } fpu_rmode_e;

    // Bit positions inside res_flags = {timeout, exception, inexact, underflow, overflow}
    localparam int FLAG_OVERFLOW  = 0;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 2;
    localparam int FLAG_EXCEPTION = 3;
    localparam int FLAG_TIMEOUT   = 4;
    localparam int FLAG_W         = 5;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_BUSY  = 2'd1,
        ARB_FLUSH = 2'd2
    } arb_state_e;

    localparam logic [63:0] DBL_ONE          = 64'h3FF0_0000_0000_0000;
    localparam logic [63:0] DBL_TWO          = 64'h4000_0000_0000_0000;
    localparam logic [63:0] DBL_TEN          = 64'h4024_0000_0000_0000;
    localparam logic [63:0] DBL_TWENTY_EIGHT = 64'h403C_0000_0000_0000;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin selector: first set request at or above the pointer, with wrap
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  onehot_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    int            pos;
    logic [IW-1:0] pos_idx;

    // Walk the requests starting at the pointer and keep the first hit
    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        pos      = 0;
        pos_idx  = '0;
        for (int k = 0; k < N; k++) begin
            pos     = (int'(ptr_i) + k) % N;
            pos_idx = IW'(pos);
            if (!valid_o && req_i[pos_idx]) begin
                valid_o           = 1'b1;
                onehot_o[pos_idx] = 1'b1;
                idx_o             = pos_idx;
            end
        end
    end

endmodule

// File: rtl/fpu_share_arb.sv
// rtl/fpu_share_arb.sv - round-robin sharing of one double-precision FPU with enable/reset sequencing and watchdog
module fpu_share_arb
    import fpu_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req,
    input  logic [3*N_REQ-1:0]  req_op,
    input  logic [2*N_REQ-1:0]  req_rmode,
    input  logic [64*N_REQ-1:0] req_opa,
    input  logic [64*N_REQ-1:0] req_opb,
    output logic [N_REQ-1:0]    grant,
    output logic [N_REQ-1:0]    done,
    output logic [63:0]         result,
    output logic [4:0]          res_flags,
    output logic                busy,
    output logic                fpu_rst,
    output logic                fpu_enable,
    output logic [2:0]          fpu_op,
    output logic [1:0]          fpu_rmode,
    output logic [63:0]         fpu_opa,
    output logic [63:0]         fpu_opb,
    input  logic [63:0]         fpu_out,
    input  logic                fpu_ready,
    input  logic                fpu_overflow,
    input  logic                fpu_underflow,
    input  logic                fpu_inexact,
    input  logic                fpu_exception
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    arb_state_e       state_q;
    logic [IW-1:0]    ptr_q;
    logic [IW-1:0]    win_q;
    logic [CW-1:0]    cnt_q;
    logic [N_REQ-1:0] grant_q;
    logic [N_REQ-1:0] done_q;
    logic [63:0]      result_q;
    logic [4:0]       flags_q;
    logic             fpu_rst_q;
    logic             fpu_enable_q;
    logic [2:0]       op_q;
    logic [1:0]       rmode_q;
    logic [63:0]      opa_q;
    logic [63:0]      opb_q;

    logic [N_REQ-1:0] pick_onehot;
    logic [IW-1:0]    pick_idx;
    logic             pick_valid;
    logic [2:0]       sel_op;
    logic [1:0]       sel_rmode;
    logic [63:0]      sel_opa;
    logic [63:0]      sel_opb;
    logic [4:0]       fpu_flags;
    logic [IW-1:0]    ptr_d;

    rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_rr_pick (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx),
        .valid_o  (pick_valid)
    );

    // Operand mux driven by the one-hot winner so only its slices reach the FPU registers
    always_comb begin
        sel_op    = '0;
        sel_rmode = '0;
        sel_opa   = '0;
        sel_opb   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_onehot[i]) begin
                sel_op    = req_op[3*i +: 3];
                sel_rmode = req_rmode[2*i +: 2];
                sel_opa   = req_opa[64*i +: 64];
                sel_opb   = req_opb[64*i +: 64];
            end
        end
    end

    // Flag word on a normal completion; timeout bit is only set by the watchdog path
    always_comb begin
        fpu_flags                 = '0;
        fpu_flags[FLAG_OVERFLOW]  = fpu_overflow;
        fpu_flags[FLAG_UNDERFLOW] = fpu_underflow;
        fpu_flags[FLAG_INEXACT]   = fpu_inexact;
        fpu_flags[FLAG_EXCEPTION] = fpu_exception;
    end

    // The requester after the one just served becomes highest priority next time
    always_comb begin
        ptr_d = (win_q == IW'(N_REQ - 1)) ? '0 : win_q + IW'(1);
    end

    // Arbitration/sequencing FSM with all outputs registered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ARB_IDLE;
            ptr_q        <= '0;
            win_q        <= '0;
            cnt_q        <= '0;
            grant_q      <= '0;
            done_q       <= '0;
            result_q     <= '0;
            flags_q      <= '0;
            fpu_rst_q    <= 1'b1;
            fpu_enable_q <= 1'b0;
            op_q         <= '0;
            rmode_q      <= '0;
            opa_q        <= '0;
            opb_q        <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    fpu_rst_q <= 1'b0;
                    if (pick_valid) begin
                        grant_q      <= pick_onehot;
                        win_q        <= pick_idx;
                        op_q         <= sel_op;
                        rmode_q      <= sel_rmode;
                        opa_q        <= sel_opa;
                        opb_q        <= sel_opb;
                        fpu_enable_q <= 1'b1;
                        cnt_q        <= '0;
                        state_q      <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (fpu_ready || (cnt_q == CW'(TIMEOUT - 1))) begin
                        done_q       <= grant_q;
                        fpu_enable_q <= 1'b0;
                        fpu_rst_q    <= 1'b1;
                        state_q      <= ARB_FLUSH;
                        if (fpu_ready) begin
                            result_q <= fpu_out;
                            flags_q  <= fpu_flags;
                        end else begin
                            result_q <= '0;
                            flags_q  <= 5'b1_0000;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ARB_FLUSH: begin
                    done_q    <= '0;
                    fpu_rst_q <= 1'b0;
                    grant_q   <= '0;
                    ptr_q     <= ptr_d;
                    state_q   <= ARB_IDLE;
                end
                default: begin
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

    assign grant      = grant_q;
    assign done       = done_q;
    assign result     = result_q;
    assign res_flags  = flags_q;
    assign busy       = (state_q != ARB_IDLE);
    assign fpu_rst    = fpu_rst_q;
    assign fpu_enable = fpu_enable_q;
    assign fpu_op     = op_q;
    assign fpu_rmode  = rmode_q;
    assign fpu_opa    = opa_q;
    assign fpu_opb    = opb_q;

endmodule

// File: tb/tb_fpu_share_arb.sv
// tb/tb_fpu_share_arb.sv - self-checking bench for fpu_share_arb with a behavioural FPU stub
module tb_fpu_share_arb;
    import fpu_pkg::*;

    localparam int N       = 4;
    localparam int TMO     = 40;
    localparam int LAT     = 4;
    localparam int LAT_DIV = 12;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [3*N-1:0]  req_op;
    logic [2*N-1:0]  req_rmode;
    logic [64*N-1:0] req_opa;
    logic [64*N-1:0] req_opb;
    logic [N-1:0]    grant;
    logic [N-1:0]    done;
    logic [63:0]     result;
    logic [4:0]      res_flags;
    logic            busy;
    logic            fpu_rst;
    logic            fpu_enable;
    logic [2:0]      fpu_op;
    logic [1:0]      fpu_rmode;
    logic [63:0]     fpu_opa;
    logic [63:0]     fpu_opb;
    logic [63:0]     fpu_out = '0;
    logic            fpu_ready = 1'b0;
    logic            fpu_overflow;
    logic            fpu_underflow;
    logic            fpu_inexact;
    logic            fpu_exception;

    logic            stub_never;
    logic [3:0]      stub_flags;
    int              stub_cnt = 0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fpu_share_arb #(
        .N_REQ   (N),
        .TIMEOUT (TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .req_op        (req_op),
        .req_rmode     (req_rmode),
        .req_opa       (req_opa),
        .req_opb       (req_opb),
        .grant         (grant),
        .done          (done),
        .result        (result),
        .res_flags     (res_flags),
        .busy          (busy),
        .fpu_rst       (fpu_rst),
        .fpu_enable    (fpu_enable),
        .fpu_op        (fpu_op),
        .fpu_rmode     (fpu_rmode),
        .fpu_opa       (fpu_opa),
        .fpu_opb       (fpu_opb),
        .fpu_out       (fpu_out),
        .fpu_ready     (fpu_ready),
        .fpu_overflow  (fpu_overflow),
        .fpu_underflow (fpu_underflow),
        .fpu_inexact   (fpu_inexact),
        .fpu_exception (fpu_exception)
    );

    assign fpu_exception = stub_flags[3];
    assign fpu_inexact   = stub_flags[2];
    assign fpu_underflow = stub_flags[1];
    assign fpu_overflow  = stub_flags[0];

    function automatic logic [63:0] stub_calc(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        real x, y, r;
        x = $bitstoreal(a);
        y = $bitstoreal(b);
        case (op)
            3'd0:    r = x + y;
            3'd1:    r = x - y;
            3'd2:    r = x * y;
            default: r = x / y;
        endcase
        return $realtobits(r);
    endfunction

    // FPU stub: ready after a fixed latency while enabled, cleared by fpu_rst
    always @(posedge clk) begin
        if (fpu_rst || !fpu_enable) begin
            stub_cnt  <= 0;
            fpu_ready <= 1'b0;
        end else if (!stub_never) begin
            stub_cnt <= stub_cnt + 1;
            if (stub_cnt + 1 == ((fpu_op == 3'd3) ? LAT_DIV : LAT)) begin
                fpu_ready <= 1'b1;
                fpu_out   <= stub_calc(fpu_op, fpu_opa, fpu_opb);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_slot(input int i, input logic [2:0] op, input logic [1:0] rm,
                            input logic [63:0] a, input logic [63:0] b);
        req_op[3*i +: 3]     = op;
        req_rmode[2*i +: 2]  = rm;
        req_opa[64*i +: 64]  = a;
        req_opb[64*i +: 64]  = b;
    endtask

    task automatic wait_grant(input int budget, output bit ok);
        int cyc;
        ok  = 1'b0;
        cyc = 0;
        while (cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (grant != '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_done(input int budget, output bit ok, output int cyc);
        ok  = 1'b0;
        cyc = 0;
        while (cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (done != '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        int          idx;
        logic [2:0]  op;
        logic [1:0]  rm;
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  fl;
        logic [63:0] exp_res;
        logic [4:0]  exp_flags;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit ok;
        int cyc;
        logic [N-1:0] exp_g;
        logic [N-1:0] prev_g;
        logic [N-1:0] cur_g;
        logic [N-1:0] order[5];
        int n_grant, n_done, t, last_done_t, dones_seen;

        reset      = 1'b1;
        req        = '0;
        req_op     = '0;
        req_rmode  = '0;
        req_opa    = '0;
        req_opb    = '0;
        stub_never = 1'b0;
        stub_flags = '0;

        vecs[0] = '{0, FPU_ADD, RM_NEAREST, DBL_ONE, DBL_TWO, 4'b0000, 64'h4008000000000000, 5'b00000};
        vecs[1] = '{1, FPU_MUL, RM_ZERO, DBL_TEN, DBL_TWENTY_EIGHT, 4'b0100, 64'h4071800000000000, 5'b00100};
        vecs[2] = '{2, FPU_SUB, RM_POS_INF, DBL_TWENTY_EIGHT, DBL_TEN, 4'b0000, 64'h4032000000000000, 5'b00000};
        vecs[3] = '{3, FPU_DIV, RM_NEG_INF, DBL_ONE, DBL_TWO, 4'b1001, 64'h3FE0000000000000, 5'b01001};
        vecs[4] = '{0, FPU_ADD, RM_NEAREST, DBL_TEN, DBL_TWENTY_EIGHT, 4'b0010, 64'h4043000000000000, 5'b00010};
        vecs[5] = '{2, FPU_DIV, RM_ZERO, DBL_TWENTY_EIGHT, DBL_TWO, 4'b0000, 64'h402C000000000000, 5'b00000};

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_grant", 64'(grant), 64'h0);
        chk("rst_done", 64'(done), 64'h0);
        chk("rst_result", result, 64'h0);
        chk("rst_flags", 64'(res_flags), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_fpu_rst", 64'(fpu_rst), 64'h1);
        chk("rst_fpu_enable", 64'(fpu_enable), 64'h0);
        reset = 1'b0;

        // table-driven single-requester operations
        for (int v = 0; v < 6; v++) begin
            set_slot(vecs[v].idx, vecs[v].op, vecs[v].rm, vecs[v].a, vecs[v].b);
            stub_flags = vecs[v].fl;
            exp_g      = N'(1) << vecs[v].idx;
            req        = exp_g;
            wait_grant(10, ok);
            chk("vec_grant_seen", 64'(ok), 64'h1);
            chk("vec_grant", 64'(grant), 64'(exp_g));
            chk("vec_enable", 64'(fpu_enable), 64'h1);
            chk("vec_op", 64'(fpu_op), 64'(vecs[v].op));
            chk("vec_rmode", 64'(fpu_rmode), 64'(vecs[v].rm));
            chk("vec_opa", fpu_opa, vecs[v].a);
            chk("vec_opb", fpu_opb, vecs[v].b);
            wait_done(TMO + 5, ok, cyc);
            chk("vec_done_seen", 64'(ok), 64'h1);
            chk("vec_done", 64'(done), 64'(exp_g));
            chk("vec_result", result, vecs[v].exp_res);
            chk("vec_flags", 64'(res_flags), 64'(vecs[v].exp_flags));
            chk("vec_fpu_rst_pulse", 64'(fpu_rst), 64'h1);
            chk("vec_enable_off", 64'(fpu_enable), 64'h0);
            req = '0;
            @(negedge clk);
            chk("vec_done_1cyc", 64'(done), 64'h0);
            chk("vec_fpu_rst_1cyc", 64'(fpu_rst), 64'h0);
            chk("vec_grant_fall", 64'(grant), 64'h0);
            chk("vec_busy_idle", 64'(busy), 64'h0);
            chk("vec_result_hold", result, vecs[v].exp_res);
        end

        // fairness: all requesters held from reset
        reset      = 1'b1;
        stub_flags = '0;
        for (int i = 0; i < N; i++) set_slot(i, FPU_MUL, RM_NEAREST, DBL_TEN, DBL_TWENTY_EIGHT);
        req = '1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
        order[3] = 4'b1000; order[4] = 4'b0001;
        prev_g      = '0;
        n_grant     = 0;
        n_done      = 0;
        last_done_t = 0;
        t           = 0;
        while (t < 200 && n_done < 5) begin
            @(negedge clk);
            t++;
            cur_g = grant;
            if (cur_g != '0 && prev_g == '0 && n_grant < 5) begin
                chk("fair_order", 64'(cur_g), 64'(order[n_grant]));
                if (n_grant > 0) chk("fair_gap", 64'(t - last_done_t), 64'd2);
                n_grant++;
            end
            if (done != '0) begin
                chk("fair_done", 64'(done), 64'(cur_g));
                chk("fair_result", result, 64'h4071800000000000);
                last_done_t = t;
                n_done++;
            end
            prev_g = cur_g;
        end
        chk("fair_count", 64'(n_done), 64'd5);

        // sub with req dropped one cycle after grant
        do_reset();
        set_slot(2, FPU_SUB, RM_NEAREST, DBL_TWENTY_EIGHT, DBL_TEN);
        req = 4'b0100;
        wait_grant(10, ok);
        chk("drop_grant", 64'(grant), 64'h4);
        @(negedge clk);
        req = '0;
        wait_done(TMO + 5, ok, cyc);
        chk("drop_done_seen", 64'(ok), 64'h1);
        chk("drop_done", 64'(done), 64'h4);
        chk("drop_result", result, 64'h4032000000000000);
        repeat (2) @(negedge clk);

        // watchdog: FPU never becomes ready
        stub_never = 1'b1;
        set_slot(1, FPU_ADD, RM_NEAREST, DBL_ONE, DBL_TWO);
        req = 4'b0010;
        wait_grant(10, ok);
        chk("wd_enable", 64'(fpu_enable), 64'h1);
        wait_done(TMO + 10, ok, cyc);
        chk("wd_done_seen", 64'(ok), 64'h1);
        chk("wd_latency", 64'(cyc), 64'(TMO));
        chk("wd_done", 64'(done), 64'h2);
        chk("wd_flags", 64'(res_flags), 64'h10);
        chk("wd_result", result, 64'h0);
        req = '0;
        repeat (2) @(negedge clk);
        stub_never = 1'b0;

        // asynchronous reset five cycles into a divide
        do_reset();
        set_slot(3, FPU_DIV, RM_NEAREST, DBL_ONE, DBL_TWO);
        req = 4'b1000;
        wait_grant(10, ok);
        chk("rb_grant", 64'(grant), 64'h8);
        repeat (5) @(negedge clk);
        chk("rb_still_busy", 64'(busy), 64'h1);
        #2;
        reset = 1'b1;
        req   = '0;
        #1;
        chk("rb_grant0", 64'(grant), 64'h0);
        chk("rb_enable0", 64'(fpu_enable), 64'h0);
        chk("rb_fpu_rst1", 64'(fpu_rst), 64'h1);
        chk("rb_busy0", 64'(busy), 64'h0);
        chk("rb_done0", 64'(done), 64'h0);
        dones_seen = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (k == 1) reset = 1'b0;
            if (done != '0) dones_seen++;
        end
        chk("rb_no_done", 64'(dones_seen), 64'h0);
        set_slot(1, FPU_DIV, RM_NEAREST, DBL_ONE, DBL_TWO);
        req = 4'b0010;
        wait_done(TMO + 5, ok, cyc);
        chk("rb_after_done", 64'(done), 64'h2);
        chk("rb_after_result", result, 64'h3FE0000000000000);
        req = '0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
